regfile_dump_ctrl: RTL
======================

Name: regfile_dump_ctrl

Overview:
Debug-side sequencer and read-port arbiter for the CPU register file.
- On request, and once the pipeline is halted, it takes read port 1, walks every register from address 0 up to N_REGS-1, and streams each 32-bit value out over a valid/ready handshake to the debug serializer.
- When idle, or while waiting for the halt, it passes the pipeline's decode-stage read address straight through to the register file.

Parameters:
NB_DATA, 32, register data width
NB_ADDR, 5, register address width
N_REGS, 32, number of registers dumped (at most 2**NB_ADDR)

Ports:
clk  in  1  system clock; all state changes on rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  dump request, sampled in IDLE only
i_halted  in  1  pipeline halted (no register file writes in flight)
i_pipe_rd_addr  in  NB_ADDR  pipeline read-port-1 address
o_rf_rd_addr  out  NB_ADDR  address to register file read port 1
i_rf_rd_data  in  NB_DATA  register file read port 1 data (registered, 1-cycle latency)
o_data  out  NB_DATA  dumped register value
o_valid  out  1  o_data valid
i_ready  in  1  downstream accepts o_data
o_last  out  1  current word is register N_REGS-1
o_busy  out  1  dump in progress (state != IDLE)
o_done  out  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, idx=0, o_data=0, o_valid=0, o_last=0, o_done=0, o_busy=0.
  - Reset mid-dump aborts immediately; no o_done is produced.
- States: IDLE, WAIT_HALT, ADDR, CAPTURE, SEND, DONE.
- Address mux (combinational):
  - o_rf_rd_addr = i_pipe_rd_addr in IDLE and WAIT_HALT.
  - o_rf_rd_addr = idx in ADDR, CAPTURE, SEND and DONE.
- IDLE: if i_start=1, clear idx to 0 and go to WAIT_HALT.
- WAIT_HALT: stay while i_halted=0; go to ADDR when i_halted=1.
- ADDR: idx is presented to the register file, which latches it at this edge.
  - If i_halted=0, go to WAIT_HALT and keep idx.
  - Otherwise go to CAPTURE.
- CAPTURE: i_rf_rd_data is valid for idx.
  - If i_halted=0, go to WAIT_HALT and keep idx (the word is re-read later).
  - Otherwise register o_data <= i_rf_rd_data, set o_valid=1, go to SEND.
- SEND:
  - o_valid stays 1 and o_data stays stable until o_valid & i_ready; i_halted is ignored here.
  - On handshake: o_valid=0. If idx==N_REGS-1 go to DONE; otherwise idx++ and go to ADDR.
- DONE: o_done=1 for this single cycle, idx reset to 0, then go to IDLE.
- o_last = o_valid & (idx==N_REGS-1).
- i_start is ignored in every state except IDLE (no queuing).
- idx is NB_ADDR bits wide; it never wraps, because termination is the compare against N_REGS-1.
- Throughput with i_ready held at 1: 3 cycles per word.
  - Numbering edges from the edge that samples i_start as edge 0, with i_halted=1: word k is valid after edge 3+3k and accepted at edge 4+3k.
  - o_done is high in the cycle after edge 97.
- Register value order on the stream is strictly ascending address, with no duplicates and no gaps.
- A halt drop is recovered by re-reading the same idx.

Test Plan:
1. Full dump, no backpressure: preload reg k = 0x1000+k, i_halted=1, i_ready=1, pulse i_start.
   - Expect 32 handshakes carrying 0x1000..0x101F in order.
   - o_last only on 0x101F.
   - Word 0 valid after edge 3; o_done single pulse after edge 97; o_busy low afterwards.
2. Backpressure: drive i_ready low for 5 cycles while word 4 is valid.
   - o_valid stays 1 and o_data stays 0x1004 throughout.
   - Stream continues with 0x1005; every word still delivered exactly once.
3. Halt wait: i_start with i_halted=0 for 10 cycles.
   - o_rf_rd_addr follows i_pipe_rd_addr, o_busy=1, o_valid=0.
   - Raise i_halted: dump proceeds normally from word 0.
4. Halt drop: drop i_halted during CAPTURE of word 7 for 3 cycles.
   - No word 7 is emitted before halt returns; o_rf_rd_addr follows i_pipe_rd_addr during the drop.
   - After recovery, word 7 = 0x1007 is emitted once.
5. Start while busy: pulse i_start during word 10.
   - Ignored; exactly one o_done; 32 words total.
6. Async reset: assert i_rst_n=0 mid-cycle during SEND of word 20.
   - o_valid, o_busy and o_data go to 0 immediately; no o_done.
   - A fresh i_start after release dumps from word 0.

Source files
------------

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl
//   Debug-side sequencer and read-port-1 arbiter for the CPU register file.
//   On i_start it waits for the pipeline to halt. It then walks registers
//   0..N_REGS-1 through read port 1 and streams each value out over a
//   valid/ready handshake. While idle, or while waiting for the halt, the
//   pipeline's decode-stage read address passes straight through.
//
// Ports
//   clk, i_rst_n      clock, async active-low reset
//   i_start           dump request (honoured only in IDLE)
//   i_halted          pipeline halted, no writes in flight
//   i_pipe_rd_addr    pipeline read-port-1 address
//   o_rf_rd_addr      muxed address to register file read port 1
//   i_rf_rd_data      read port 1 data, 1-cycle registered latency
//   o_data/o_valid    dumped word and its valid
//   i_ready           downstream accepts o_data
//   o_last            current word is register N_REGS-1
//   o_busy            dump in progress
//   o_done            one-cycle pulse after the final word is accepted
module regfile_dump_ctrl #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 32
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_halted,
    input  logic [NB_ADDR-1:0] i_pipe_rd_addr,
    output logic [NB_ADDR-1:0] o_rf_rd_addr,
    input  logic [NB_DATA-1:0] i_rf_rd_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_last,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [2:0] {
        IDLE, WAIT_HALT, ADDR, CAPTURE, SEND, DONE
    } state_t;

    localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(N_REGS - 1);

    state_t             r_state, w_next;
    logic [NB_ADDR-1:0] r_idx,   w_idx_next;
    logic [NB_DATA-1:0] r_data,  w_data_next;
    logic               r_valid, w_valid_next;
    logic               w_is_last;

    assign w_is_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_idx_next   = r_idx;
        w_data_next  = r_data;
        w_valid_next = r_valid;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_idx_next = '0;
                    w_next     = WAIT_HALT;
                end
            end
            WAIT_HALT: begin
                if (i_halted) w_next = ADDR;
            end
            // The register file latches idx at the edge leaving ADDR.
            ADDR: begin
                w_next = i_halted ? CAPTURE : WAIT_HALT;
            end
            // A halt drop here discards the read; idx is kept and re-read.
            CAPTURE: begin
                if (!i_halted) begin
                    w_next = WAIT_HALT;
                end else begin
                    w_data_next  = i_rf_rd_data;
                    w_valid_next = 1'b1;
                    w_next       = SEND;
                end
            end
            // Halt is ignored once the word is captured.
            SEND: begin
                if (i_ready) begin
                    w_valid_next = 1'b0;
                    if (w_is_last) begin
                        w_next = DONE;
                    end else begin
                        w_idx_next = r_idx + NB_ADDR'(1);
                        w_next     = ADDR;
                    end
                end
            end
            DONE: begin
                w_idx_next = '0;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_rf_rd_addr = (r_state == IDLE || r_state == WAIT_HALT) ? i_pipe_rd_addr : r_idx;
    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_last       = r_valid & w_is_last;
    assign o_busy       = (r_state != IDLE);
    assign o_done       = (r_state == DONE);

endmodule
